imem_responder: RTL and testbench

Responder end of the instruction-fetch interface: accepts fetch requests (byte PC) from the fetch stage over a valid/ready handshake, reads a 1024×32 instruction memory, and returns the instruction word with its PC after a fixed, parameterised latency. It sits between the fetch stage and the instruction store. It supports multiple outstanding requests, back-pressure on responses, and a redirect flush that drops all in-flight fetches on branch or jump.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_responder_if.sv | 34 +++
 rtl/imem_rsp_fifo.sv | 78 +++++++
 rtl/imem_responder.sv | 137 +++++++++++++
 tb/tb_imem_responder.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared types and constants for the instruction-memory responder slice.
//   IMEM_WORDS / IMEM_IDX_W : size and word-index width of the instruction store
//   imem_rsp_t              : one in-flight fetch result (pc, instr, err), used
//                             both in the delay pipe and the response FIFO
//   is_misaligned()         : true when a byte PC is not word aligned
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_WORDS = 1024;
  localparam int IMEM_IDX_W = 10;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } imem_rsp_t;

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// ---------------------------------------------------------------------------
// imem_responder_if
// Fetch-stage <-> instruction-memory responder bundle.
//   req_valid / req_ready / req_addr : fetch request handshake (byte PC)
//   flush                            : redirect, drops every in-flight fetch
//   rsp_valid / rsp_ready            : response handshake
//   rsp_instr / rsp_pc / rsp_err     : response payload
// Modports:
//   master : fetch stage (drives requests, flush and rsp_ready)
//   slave  : responder   (drives req_ready and the response)
// ---------------------------------------------------------------------------
interface imem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
  );

endinterface

// File: rtl/imem_rsp_fifo.sv
// ---------------------------------------------------------------------------
// imem_rsp_fifo
// Synchronous FIFO of imem_rsp_t entries holding completed fetches until the
// consumer takes them.
//   clk, rst          : clock, asynchronous active-high reset
//   clear             : synchronous clear (redirect flush), wins over push/pop
//   push, push_data   : enqueue one entry (ignored when full)
//   pop               : dequeue the head entry (ignored when empty)
//   pop_data          : head entry, all zeros while empty
//   full, empty       : occupancy flags
// ---------------------------------------------------------------------------
module imem_rsp_fifo
  import imem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      push,
  input  imem_rsp_t push_data,
  input  logic      pop,
  output imem_rsp_t pop_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  imem_rsp_t        storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Zeroed while empty so the response payload reads 0 after reset and flush.
  assign pop_data = empty ? '0 : storage[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
    end else if (do_push && !clear) begin
      storage[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
// Responder end of the instruction-fetch interface. Accepts byte-PC fetch
// requests, reads a 1024x32 instruction store and returns {instr, pc, err}
// LATENCY cycles after acceptance, in request order, with back-pressure and
// a redirect flush that discards everything in flight.
// Parameters:
//   LATENCY         : request accept to earliest rsp_valid, 1..4
//   MAX_OUTSTANDING : accepted-but-unconsumed limit, >= LATENCY
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : request / response handshake and flush
//   init_we         : loader write strobe
//   init_addr       : loader word index
//   init_data       : loader write data
// ---------------------------------------------------------------------------
module imem_responder
  import imem_pkg::*;
#(
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  imem_responder_if.slave       bus,
  input  logic                  init_we,
  input  logic [IMEM_IDX_W-1:0] init_addr,
  input  logic [31:0]           init_data
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]           mem [IMEM_WORDS];
  logic [CNT_W-1:0]      outstanding;
  logic                  accept;
  logic                  transfer;
  logic [IMEM_IDX_W-1:0] word_idx;
  imem_rsp_t             new_entry;
  logic                  push;
  imem_rsp_t             push_data;
  imem_rsp_t             fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full_unused;
  logic                  unused_addr_bits;

  // Upper PC bits do not select memory: the store aliases every 4 KiB.
  assign word_idx         = bus.req_addr[11:2];
  assign unused_addr_bits = ^bus.req_addr[31:12];

  assign bus.req_ready = !rst && !bus.flush && (outstanding < CNT_W'(MAX_OUTSTANDING));
  assign accept        = bus.req_valid && bus.req_ready;
  assign transfer      = bus.rsp_valid && bus.rsp_ready;

  // Misaligned fetches never look at memory and answer with a zero word.
  always_comb begin
    new_entry       = '0;
    new_entry.pc    = bus.req_addr;
    new_entry.err   = is_misaligned(bus.req_addr[1:0]);
    new_entry.instr = new_entry.err ? 32'h0 : mem[word_idx];
  end

  // Loader port. The request path samples mem in the same edge, so a
  // same-cycle read of the written word sees the old contents.
  always_ff @(posedge clk) begin
    if (init_we) mem[init_addr] <= init_data;
  end

  // The pipe never stalls: the FIFO always has room because the outstanding
  // limit equals its depth, so stage contents simply march forward.
  generate
    if (LATENCY > 1) begin : g_pipe
      localparam int STAGES = LATENCY - 1;
      logic      stage_valid [STAGES];
      imem_rsp_t stage_data  [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < STAGES; i++) begin
            stage_valid[i] <= 1'b0;
            stage_data[i]  <= '0;
          end
        end else if (bus.flush) begin
          for (int i = 0; i < STAGES; i++) stage_valid[i] <= 1'b0;
        end else begin
          stage_valid[0] <= accept;
          stage_data[0]  <= new_entry;
          for (int i = 1; i < STAGES; i++) begin
            stage_valid[i] <= stage_valid[i-1];
            stage_data[i]  <= stage_data[i-1];
          end
        end
      end

      assign push      = stage_valid[STAGES-1];
      assign push_data = stage_data[STAGES-1];
    end else begin : g_direct
      assign push      = accept;
      assign push_data = new_entry;
    end
  endgenerate

  imem_rsp_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (bus.flush),
    .push     (push),
    .push_data(push_data),
    .pop      (transfer),
    .pop_data (fifo_head),
    .full     (fifo_full_unused),
    .empty    (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_pc    = fifo_head.pc;
  assign bus.rsp_instr = fifo_head.instr;
  assign bus.rsp_err   = fifo_head.err;

  // Counts fetches accepted but not yet handed to the consumer, including
  // those still in the delay pipe. Flush empties everything, so it clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else if (bus.flush) begin
      outstanding <= '0;
    end else begin
      case ({accept, transfer})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// ---------------------------------------------------------------------------
// tb_imem_responder
// Self-checking bench for imem_responder. A reference model tracks memory
// contents and the ordered list of accepted fetches; a negedge monitor
// compares every response, req_ready and rsp_valid against it.
// ---------------------------------------------------------------------------
module tb_imem_responder;
  import imem_pkg::*;

  localparam int LATENCY = 2;
  localparam int MAX_OUT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_we;
  logic [9:0]  init_addr;
  logic [31:0] init_data;

  imem_responder_if bus ();

  imem_responder #(
    .LATENCY        (LATENCY),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .init_we  (init_we),
    .init_addr(init_addr),
    .init_data(init_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: timed out waiting, got no event, expected one (cycle %0d)",
             name, cyc);
  endtask

  // Reference model: memory image plus the in-order list of fetches the
  // responder owes us, each tagged with the cycle it was accepted in.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
    int          acc;
  } exp_t;

  logic [31:0] model_mem [1024];
  exp_t        sb [$];
  int          accept_count   = 0;
  int          transfer_count = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    logic exp_ready;
    logic exp_valid;
    if (rst) begin
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      sb.delete();
    end else begin
      exp_ready = !bus.flush && (sb.size() < MAX_OUT);
      exp_valid = (sb.size() > 0) && (cyc >= sb[0].acc + LATENCY);
      checkOutput("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      if (bus.rsp_valid && sb.size() > 0) begin
        checkOutput("rsp_pc",    bus.rsp_pc,           sb[0].pc);
        checkOutput("rsp_instr", bus.rsp_instr,        sb[0].instr);
        checkOutput("rsp_err",   32'(bus.rsp_err),     32'(sb[0].err));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        transfer_count++;
        if (sb.size() > 0) void'(sb.pop_front());
      end
      if (bus.flush) sb.delete();
      if (bus.req_valid && bus.req_ready) begin
        accept_count++;
        e.pc    = bus.req_addr;
        e.err   = (bus.req_addr % 4) != 0;
        e.instr = e.err ? 32'h0 : model_mem[(bus.req_addr / 4) % 1024];
        e.acc   = cyc;
        sb.push_back(e);
      end
    end
    if (init_we) model_mem[init_addr] = init_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] addr,
                               input logic rr, input logic fl);
    bus.req_valid = rv;
    bus.req_addr  = addr;
    bus.rsp_ready = rr;
    bus.flush     = fl;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || bus.rsp_valid) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) reportTimeout(name);
  endtask

  initial begin : stimulus
    int start;
    int a0;
    int t0;
    logic found;
    logic [31:0] addr;

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = 32'h0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;
    init_we       = 1'b0;
    init_addr     = '0;
    init_data     = '0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checkOutput("post_reset_req_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("post_reset_rsp_instr", bus.rsp_instr, 32'h0);
    checkOutput("post_reset_rsp_pc",    bus.rsp_pc,    32'h0);
    checkOutput("post_reset_rsp_err",   32'(bus.rsp_err), 32'd0);

    for (int i = 0; i < 1024; i++) begin
      init_we   = 1'b1;
      init_addr = 10'(i);
      init_data = (i == 5) ? 32'h8C08_0004 : $urandom;
      tick();
    end
    init_we = 1'b0;
    tick();

    // Single fetch with exact latency.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_0014;
    bus.rsp_ready = 1'b1;
    start = cyc;
    tick();
    bus.req_valid = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 10 && !found; n++) begin
      @(negedge clk);
      if (bus.rsp_valid) found = 1'b1;
    end
    if (!found) reportTimeout("single_fetch_valid");
    else begin
      checkOutput("single_fetch_latency", 32'(cyc - start), 32'(LATENCY));
      checkOutput("single_fetch_instr",   bus.rsp_instr, 32'h8C08_0004);
      checkOutput("single_fetch_pc",      bus.rsp_pc,    32'h0000_0014);
      checkOutput("single_fetch_err",     32'(bus.rsp_err), 32'd0);
    end
    tick();
    drain("single_fetch_drain");

    // Streaming: req_ready must hold high across back-to-back requests.
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'(i * 4);
      bus.rsp_ready = 1'b1;
      checkOutput("stream_req_ready", 32'(bus.req_ready), 32'd1);
      tick();
    end
    t0 = transfer_count;
    drain("stream_drain");
    checkOutput("stream_responses", 32'(transfer_count - t0 + 1 >= 1 ? 1 : 0), 32'd1);

    // Back-pressure: only MAX_OUT accepts while the consumer stalls.
    a0 = accept_count;
    for (int i = 0; i < 6; i++)
      applyStimulus(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    checkOutput("bp_accepts",       32'(accept_count - a0), 32'd3);
    checkOutput("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    bus.rsp_ready = 1'b0;
    checkOutput("bp_req_ready_rerise", 32'(bus.req_ready), 32'd1);
    tick();
    drain("bp_drain");

    // Flush with three outstanding, then a fresh fetch.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    t0 = transfer_count;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b1, 1'b0);
    drain("flush_drain");
    checkOutput("flush_transfers", 32'(transfer_count - t0), 32'd1);

    // Misaligned and 4 KiB alias.
    applyStimulus(1'b1, 32'h0000_0016, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h0000_1014, 1'b1, 1'b0);
    drain("misalign_alias_drain");

    // Same-cycle loader write and read of one word returns old data.
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h20;
    init_we       = 1'b1;
    init_addr     = 10'd8;
    init_data     = 32'hDEAD_BEEF;
    tick();
    init_we = 1'b0;
    drain("read_first_drain");
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0);
    drain("read_after_write_drain");

    // Reset with two fetches outstanding.
    applyStimulus(1'b1, 32'h300, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h304, 1'b0, 1'b0);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (10) tick();

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      addr = {$urandom_range(0, 32'hF_FFFF) & 32'hF_FFFF, 12'h000} |
             {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
      applyStimulus(1'($urandom_range(0, 1)), addr,
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0));
    end
    drain("random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
